// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if
//   Bundles the requester-side and display-side signals of the arbiter.
//   master : requester/display side (drives req/data/blink, observes grant
//            and the display outputs)
//   slave  : the arbiter itself
//   req           3   level-sensitive request per requester 0..2
//   data0..2      16  four hex digits per requester (digit 0 = bits 3:0)
//   blink0..2     4   per-digit blink mask per requester
//   grant         3   one-hot current owner, 0 when idle
//   disp_enable   1   display enable, high exactly when grant != 0
//   disp_numbers  16  digits forwarded to the display
//   disp_blink    4   blink mask forwarded to the display
interface seg_display_arbiter_if;
  logic [2:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [3:0]  blink0;
  logic [3:0]  blink1;
  logic [3:0]  blink2;
  logic [2:0]  grant;
  logic        disp_enable;
  logic [15:0] disp_numbers;
  logic [3:0]  disp_blink;

  modport master (
    output req, data0, data1, data2, blink0, blink1, blink2,
    input  grant, disp_enable, disp_numbers, disp_blink
  );

  modport slave (
    input  req, data0, data1, data2, blink0, blink1, blink2,
    output grant, disp_enable, disp_numbers, disp_blink
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Round-robin owner selection for the shared four-digit seven-segment
//   display. An owner keeps the display for at least HOLD_CYCLES cycles and
//   is preempted after MAX_CYCLES cycles if another requester is waiting.
//   All outputs are registered; there is always one dark cycle between owners.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : slave side of seg_display_arbiter_if (requests, data, display)
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 12500000,
  parameter int unsigned MAX_CYCLES  = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_display_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OWN} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [2:0]       grant_q, grant_d;
  logic             en_q, en_d;
  logic [15:0]      num_q, num_d;
  logic [3:0]       blink_q, blink_d;

  logic [1:0]       pick_idx;
  logic             owner_req;
  logic             other_req;
  logic [19:0]      pick_src;
  logic [19:0]      own_src;

  // {blink, data} of requester i
  function automatic logic [19:0] sel_src(input logic [1:0] i,
                                          input logic [19:0] s0,
                                          input logic [19:0] s1,
                                          input logic [19:0] s2);
    case (i)
      2'd0:    return s0;
      2'd1:    return s1;
      default: return s2;
    endcase
  endfunction

  // Rotating priority starting at last_q+1 (mod 3)
  always_comb begin
    pick_idx = 2'd0;
    case (last_q)
      2'd0:    pick_idx = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd1:    pick_idx = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: pick_idx = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // last_q always holds the current owner's index while not idle
  assign owner_req = bus.req[last_q];
  assign other_req = |(bus.req & ~grant_q);
  assign pick_src  = sel_src(pick_idx, {bus.blink0, bus.data0},
                             {bus.blink1, bus.data1}, {bus.blink2, bus.data2});
  assign own_src   = sel_src(last_q, {bus.blink0, bus.data0},
                             {bus.blink1, bus.data1}, {bus.blink2, bus.data2});

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd2;
      grant_q <= '0;
      en_q    <= 1'b0;
      num_q   <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      num_q   <= num_d;
      blink_q <= blink_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|bus.req) begin
          state_d = S_HOLD;
          last_d  = pick_idx;
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = owner_req ? S_OWN : S_IDLE;
        end
      end
      S_OWN: begin
        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        if (!owner_req) begin
          state_d = S_IDLE;
        end else if ((cnt_q >= MAX_LAST) && other_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: keyed on the next state so outputs are registered together
  // with the transition (cleared on the edge that enters IDLE, loaded on the
  // edge that grants).
  always_comb begin
    grant_d = grant_q;
    en_d    = en_q;
    num_d   = num_q;
    blink_d = blink_q;
    if (state_d == S_IDLE) begin
      grant_d = '0;
      en_d    = 1'b0;
      num_d   = '0;
      blink_d = '0;
    end else if (state_q == S_IDLE) begin
      grant_d = 3'b001 << pick_idx;
      en_d    = 1'b1;
      num_d   = pick_src[15:0];
      blink_d = pick_src[19:16];
    end else if (owner_req) begin
      num_d   = own_src[15:0];
      blink_d = own_src[19:16];
    end
  end

  assign bus.grant        = grant_q;
  assign bus.disp_enable  = en_q;
  assign bus.disp_numbers = num_q;
  assign bus.disp_blink   = blink_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(
    .HOLD_CYCLES (4),
    .MAX_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_grant"}, 16'(bus.grant), 16'h0);
    chk({tag, "_en"},    16'(bus.disp_enable), 16'h0);
    chk({tag, "_num"},   bus.disp_numbers, 16'h0);
    chk({tag, "_blink"}, 16'(bus.disp_blink), 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 3'b000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] seq [4];
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.data0 = '0; bus.data1 = '0; bus.data2 = '0;
    bus.blink0 = '0; bus.blink1 = '0; bus.blink2 = '0;
    tick();
    tick();
    chk_dark("reset");
    rst = 1'b0;

    // 1: single owner, tracking, release from OWN
    bus.req = 3'b001; bus.data0 = 16'h1234; bus.blink0 = 4'h2;
    tick();
    chk("t1_grant", 16'(bus.grant), 16'h0001);
    chk("t1_en",    16'(bus.disp_enable), 16'h0001);
    chk("t1_num",   bus.disp_numbers, 16'h1234);
    chk("t1_blink", 16'(bus.disp_blink), 16'h0002);
    bus.data0 = 16'h5678; bus.blink0 = 4'h9;
    tick();
    chk("t1_track_num",   bus.disp_numbers, 16'h5678);
    chk("t1_track_blink", 16'(bus.disp_blink), 16'h0009);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_still", 16'(bus.grant), 16'h0001);
    bus.req = 3'b000;
    tick();
    chk_dark("t1_release");

    // 2: one-cycle pulse still holds exactly 4 cycles, data frozen
    bus.req = 3'b010; bus.data1 = 16'hBEEF; bus.blink1 = 4'h5;
    tick();
    chk("t2_grant0", 16'(bus.grant), 16'h0002);
    chk("t2_num0",   bus.disp_numbers, 16'hBEEF);
    bus.req = 3'b000; bus.data1 = 16'h0000; bus.blink1 = 4'h0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("t2_grant%0d", i), 16'(bus.grant), 16'h0002);
      chk($sformatf("t2_num%0d", i),   bus.disp_numbers, 16'hBEEF);
      chk($sformatf("t2_blink%0d", i), 16'(bus.disp_blink), 16'h0005);
    end
    tick();
    chk_dark("t2_end");

    // 3: rotation under continuous requests, owners release after 5 cycles
    do_reset();
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t3_grant%0d", k), 16'(bus.grant), 16'(seq[k]));
      for (int i = 0; i < 4; i++) tick();
      chk($sformatf("t3_held%0d", k), 16'(bus.grant), 16'(seq[k]));
      bus.req = 3'b111 & ~seq[k];
      tick();
      chk($sformatf("t3_gap%0d", k), 16'(bus.grant), 16'h0000);
      bus.req = 3'b111;
    end

    // 4: preemption after 10 granted cycles
    do_reset();
    bus.req = 3'b001;
    tick();
    chk("t4_grant0", 16'(bus.grant), 16'h0001);
    for (int i = 1; i < 10; i++) begin
      if (i == 2) bus.req = 3'b101;
      tick();
      chk($sformatf("t4_grant%0d", i), 16'(bus.grant), 16'h0001);
    end
    tick();
    chk("t4_preempt", 16'(bus.grant), 16'h0000);
    tick();
    chk("t4_next", 16'(bus.grant), 16'h0004);

    // 5: long ownership with saturating counter, then handover
    do_reset();
    bus.req = 3'b010;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk($sformatf("t5_own%0d", i), 16'(bus.grant), 16'h0002);
    end
    bus.req = 3'b011;
    tick();
    chk("t5_drop", 16'(bus.grant), 16'h0000);
    tick();
    chk("t5_grant0", 16'(bus.grant), 16'h0001);

    // 6: reset during HOLD
    do_reset();
    bus.req = 3'b100; bus.data2 = 16'hCAFE; bus.blink2 = 4'hA;
    tick();
    chk("t6_grant", 16'(bus.grant), 16'h0004);
    chk("t6_num",   bus.disp_numbers, 16'hCAFE);
    tick();
    rst = 1'b1;
    bus.req = 3'b101;
    tick();
    chk_dark("t6_rst");
    rst = 1'b0;
    tick();
    chk("t6_after", 16'(bus.grant), 16'h0001);
    chk("t6_after_num", bus.disp_numbers, 16'h5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
